double_sqrt: RTL and testbench

DOUBLE_SQRT -- requirements
Module: double_sqrt

---
 rtl/double_sqrt.sv | 177 +++++++++++++++++
 tb/tb_double_sqrt.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/double_sqrt.sv
// -----------------------------------------------------------------------------
// double_sqrt
//   Fully pipelined IEEE-754 binary64 square root. It accepts one operand per
//   cycle and returns one result per cycle, 57 cycles after the operand is
//   sampled. The result is rounded to nearest, ties to even. Subnormal inputs
//   are normalized. No exception flags are produced.
//
//   Pipeline:
//     a_q          : input capture
//     st_q[0]      : unpack, classify, normalize, make the exponent even
//     st_q[1..55]  : one root bit per stage (53 significand bits + guard + round)
//     z_q          : round to nearest even and pack
//
// Ports
//   clk : clock; all state updates on the rising edge
//   rst : synchronous active-high reset; clears every pipeline register
//   a   : binary64 operand, sampled every cycle
//   z   : binary64 square root of the operand sampled 57 cycles earlier
// -----------------------------------------------------------------------------
module double_sqrt (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] a,
  output logic [63:0] z
);

  localparam int NBITS = 55;  // root bits produced by the recurrence

  // Operand class travels with its data. All-zero (the reset value) means +0,
  // so a cleared pipeline emits 0x0000000000000000.
  localparam logic [1:0] CLS_ZERO = 2'd0;
  localparam logic [1:0] CLS_NORM = 2'd1;
  localparam logic [1:0] CLS_INF  = 2'd2;
  localparam logic [1:0] CLS_NAN  = 2'd3;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] PINF = 64'h7FF0_0000_0000_0000;

  typedef struct packed {
    logic        sign;
    logic [1:0]  cls;
    logic [10:0] exp;   // biased result exponent before rounding carry
    logic [53:0] x;     // radicand, value x * 2^-52 in [1,4); consumed 2 bits/stage
    logic [57:0] rem;   // partial remainder
    logic [54:0] root;  // partial root, grows one bit per stage
  } stage_t;

  logic [63:0] a_q;
  stage_t      s1_d;
  stage_t      st_d [1:NBITS];
  stage_t      st_q [0:NBITS];
  logic [63:0] z_d, z_q;

  // Leading-zero count of a 53-bit mantissa (53 when the input is zero).
  function automatic logic [5:0] lzc53(input logic [52:0] v);
    logic found;
    lzc53 = 6'd0;
    found = 1'b0;
    for (int i = 52; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      lzc53 = lzc53 + 6'd1;
      end
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Stage 1: unpack, classify, normalize subnormals, make the exponent even.
  // ---------------------------------------------------------------------------
  logic [10:0] e_fld, e_eff;
  logic [51:0] frac_in;
  logic        e_max, e_min, frac_nz;
  logic [52:0] m53, mn;
  logic [5:0]  shift;
  logic [11:0] esum;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    s1_d    = '0;
    e_fld   = a_q[62:52];
    frac_in = a_q[51:0];
    e_max   = &e_fld;
    e_min   = ~|e_fld;
    frac_nz = |frac_in;
    m53     = {~e_min, frac_in};
    shift   = lzc53(m53);
    mn      = m53 << shift;
    e_eff   = e_min ? 11'd1 : e_fld;
    // esum = (unbiased e) + 2046. It has the parity of e, and esum/2 is
    // floor(e/2) + 1023, the biased result exponent.
    esum    = {1'b0, e_eff} + 12'd1023 - {6'd0, shift};

    s1_d.sign = a_q[63];
    if (e_max && frac_nz)        s1_d.cls = CLS_NAN;
    else if (e_min && !frac_nz)  s1_d.cls = CLS_ZERO;   // keeps sign: -0 -> -0
    else if (a_q[63])            s1_d.cls = CLS_NAN;    // negative nonzero, incl. -inf
    else if (e_max)              s1_d.cls = CLS_INF;
    else begin
      s1_d.cls = CLS_NORM;
      s1_d.exp = esum[11:1];
      // An odd exponent puts one factor of two into the radicand.
      s1_d.x   = esum[0] ? {mn, 1'b0} : {1'b0, mn};
    end
  end

  // ---------------------------------------------------------------------------
  // Stages 2..56: restoring digit recurrence on D = x << 56. Each stage brings
  // down the next two radicand bits and decides one root bit.
  // ---------------------------------------------------------------------------
  logic [57:0] rem_sh [NBITS];
  logic [57:0] trial  [NBITS];
  logic        ge     [NBITS];

  always_comb begin
    for (int i = 0; i < NBITS; i++) begin
      rem_sh[i]      = {st_q[i].rem[55:0], st_q[i].x[53:52]};
      trial[i]       = {1'b0, st_q[i].root, 2'b01};
      ge[i]          = (rem_sh[i] >= trial[i]);
      st_d[i+1]      = st_q[i];
      st_d[i+1].x    = {st_q[i].x[51:0], 2'b00};
      st_d[i+1].rem  = ge[i] ? (rem_sh[i] - trial[i]) : rem_sh[i];
      st_d[i+1].root = {st_q[i].root[53:0], ge[i]};
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 57: round to nearest even and pack.
  // ---------------------------------------------------------------------------
  stage_t      fs;
  logic        rnd_up, carry;
  logic [53:0] msum;
  logic [51:0] frac_out;

  always_comb begin
    fs       = st_q[NBITS];
    // root[54:2] is the significand, root[1] is guard and root[0] is round.
    // A nonzero remainder is the sticky bit.
    rnd_up   = fs.root[1] & (fs.root[0] | (|fs.rem) | fs.root[2]);
    msum     = {1'b0, fs.root[54:2]} + {53'd0, rnd_up};
    carry    = msum[53];
    // A rounding carry-out gives the value 2.0. Shift right one place and
    // bump the exponent.
    frac_out = carry ? msum[52:1] : msum[51:0];
    z_d      = '0;
    case (fs.cls)
      CLS_ZERO: z_d = {fs.sign, 63'd0};
      CLS_INF:  z_d = PINF;
      CLS_NAN:  z_d = QNAN;
      default:  z_d = {1'b0, fs.exp + {10'd0, carry}, frac_out};
    endcase
  end

  // ---------------------------------------------------------------------------
  // Pipeline registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: the stage array is cleared on reset as well. In-flight operands
    // must never emerge after a reset, and z must read zero until new data
    // reaches the output.
    if (rst) begin
      a_q <= '0;
      for (int i = 0; i <= NBITS; i++) st_q[i] <= '0;
      z_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its
      // predecessor's old value on the same edge.
      a_q     <= a;
      st_q[0] <= s1_d;
      for (int i = 1; i <= NBITS; i++) st_q[i] <= st_d[i];
      z_q     <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_double_sqrt.sv
// -----------------------------------------------------------------------------
// tb_double_sqrt
//   Scoreboard bench for double_sqrt. The driver pushes one expected result
//   per sampled cycle, tagged with the edge after which it must appear on z.
//   A monitor pops and compares on falling edges. Directed vectors carry
//   hand-computed results. Random streaming vectors use the simulator's
//   correctly rounded $sqrt. A reset pulse mid-stream zeroes every pending
//   expectation.
// -----------------------------------------------------------------------------
module tb_double_sqrt;

  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;
  localparam int          LAT  = 57;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a;
  logic [63:0] z;

  double_sqrt dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .z   (z)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;  // edge count after which z must hold exp
    logic [63:0] op;
    logic [63:0] exp;
  } sb_t;

  sb_t sb[$];
  int  cyc   = 0;  // rising edges seen so far
  int  total = 0;
  int  bad   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ref_sqrt(input logic [63:0] x);
    real r;
    if ((&x[62:52]) && (|x[51:0])) return QNAN;  // NaN
    if (x[62:0] == 63'd0)          return x;     // +-0
    if (x[63])                     return QNAN;  // negative nonzero
    if (&x[62:52])                 return x;     // +inf
    r = $sqrt($bitstoreal(x));
    return $realtobits(r);
  endfunction

  function automatic logic [63:0] rand_op();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel < 7)
      return {1'b0, 11'($urandom_range(1, 2046)), 52'({$urandom, $urandom})};
    else if (sel == 7)
      return {12'd0, 52'({$urandom, $urandom})};
    else
      return {$urandom, $urandom};
  endfunction

  // Apply one cycle of stimulus. Called just after a rising edge, so the value
  // is sampled on edge cyc+1 and its result is due after edge cyc+1+LAT.
  task automatic drive(input logic [63:0] op, input logic r, input logic [63:0] exp);
    sb_t e;
    a     = op;
    rst   = r;
    e.due = cyc + 1 + LAT;
    e.op  = op;
    e.exp = r ? 64'd0 : exp;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare z on falling edges against entries that are due.
  initial begin
    sb_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        total++;
        if (z !== e.exp) begin
          bad++;
          $display("FAIL sqrt@%0d op=%h: got %h, expected %h", e.due, e.op, z, e.exp);
        end
      end
    end
  end

  logic [63:0] dir_op  [13];
  logic [63:0] dir_exp [13];

  initial begin
    sb_t t;
    rst = 1'b1;
    a   = '0;

    dir_op[0]  = 64'h4010_0000_0000_0000; dir_exp[0]  = 64'h4000_0000_0000_0000; // 4 -> 2
    dir_op[1]  = 64'h4000_0000_0000_0000; dir_exp[1]  = 64'h3FF6_A09E_667F_3BCD; // 2 -> sqrt2
    dir_op[2]  = 64'h3FF0_0000_0000_0000; dir_exp[2]  = 64'h3FF0_0000_0000_0000; // 1 -> 1
    dir_op[3]  = 64'hBFF0_0000_0000_0000; dir_exp[3]  = QNAN;                    // -1
    dir_op[4]  = 64'h7FF0_0000_0000_0000; dir_exp[4]  = 64'h7FF0_0000_0000_0000; // +inf
    dir_op[5]  = 64'h8000_0000_0000_0000; dir_exp[5]  = 64'h8000_0000_0000_0000; // -0
    dir_op[6]  = 64'h7FF0_0000_0000_0001; dir_exp[6]  = QNAN;                    // sNaN
    dir_op[7]  = 64'h0000_0000_0000_0001; dir_exp[7]  = 64'h1E60_0000_0000_0000; // min subnormal
    dir_op[8]  = 64'h7FEF_FFFF_FFFF_FFFF; dir_exp[8]  = 64'h5FEF_FFFF_FFFF_FFFF; // max finite
    dir_op[9]  = 64'h0000_0000_0000_0000; dir_exp[9]  = 64'h0000_0000_0000_0000; // +0
    dir_op[10] = 64'hFFF0_0000_0000_0000; dir_exp[10] = QNAN;                    // -inf
    dir_op[11] = 64'h4022_0000_0000_0000; dir_exp[11] = 64'h4008_0000_0000_0000; // 9 -> 3
    dir_op[12] = 64'h3FD0_0000_0000_0000; dir_exp[12] = 64'h3FE0_0000_0000_0000; // 0.25 -> 0.5

    // z must read zero after every edge until the first real operand emerges.
    for (int d = 1; d <= LAT; d++) begin
      t.due = d; t.op = '0; t.exp = '0;
      sb.push_back(t);
    end

    // Initial reset.
    for (int i = 0; i < 3; i++) drive(64'd0, 1'b1, 64'd0);

    // Directed vectors, back to back, then a few zero spacers.
    for (int i = 0; i < 13; i++) drive(dir_op[i], 1'b0, dir_exp[i]);
    for (int i = 0; i < 5; i++)  drive(64'd0, 1'b0, 64'd0);

    // Random stream with a two-cycle reset in the middle.
    for (int i = 0; i < 10000; i++) begin
      logic [63:0] op;
      if (i == 5000) begin
        // Everything due from the first reset edge on must read zero.
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].due >= cyc + 1) begin
            t = sb[k]; t.exp = '0; sb[k] = t;
          end
        end
        drive(rand_op(), 1'b1, 64'd0);
        drive(rand_op(), 1'b1, 64'd0);
      end
      op = rand_op();
      drive(op, 1'b0, ref_sqrt(op));
    end

    // Drain.
    for (int i = 0; i < LAT + 3; i++) drive(64'd0, 1'b0, 64'd0);
    for (int w = 0; w < 200 && sb.size() > 0; w++) @(posedge clk);
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
